stereo_mpx_encoder: RTL and testbench

Parametrised successor stereo-multiplex encoder. Produces a composite baseband: mono (L+R)/2, plus DSB-SC subcarrier (L-R)/2·sin(2θ), plus pilot A·sin(θ), all from a single shared phase accumulator, so pilot and subcarrier are phase-coherent by construction. Runs in the audio sample-rate domain between the source mux and the FM modulator. Adds a run-time mode select, phase sync, saturation with clip statistics, and generic widths.

---
 rtl/stereo_mpx_pkg.sv | 36 +++
 rtl/mpx_sine_lut.sv | 67 ++++++
 rtl/stereo_mpx_encoder.sv | 176 +++++++++++++++++
 tb/tb_stereo_mpx_encoder.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stereo_mpx_pkg.sv
// Shared types and helpers for the stereo multiplex encoder.
//   mpx_mode_e    : run-time composition mode
//   MPX_LAT       : in_valid -> mpx_valid latency in cycles
//   mpx_saturate  : clamp a signed value into a w-bit signed range, flagging clips
package stereo_mpx_pkg;

  typedef enum logic [1:0] {
    MPX_STEREO = 2'b00,
    MPX_MONO   = 2'b01,
    MPX_PILOT  = 2'b10,
    MPX_RSVD   = 2'b11
  } mpx_mode_e;

  localparam int unsigned MPX_LAT = 5;

  function automatic logic signed [63:0] mpx_saturate(input  logic signed [63:0] x,
                                                      input  int unsigned        w,
                                                      output logic               clipped);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    logic signed [63:0] res;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    clipped = 1'b1;
    if (x > hi) begin
      res = hi;
    end else if (x < lo) begin
      res = lo;
    end else begin
      res     = x;
      clipped = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/mpx_sine_lut.sv
// Quarter-wave sine ROM with quadrant fold and a registered output.
//   clk, reset  : clock, synchronous active-high reset
//   phase_idx_i : LUT_AW+2 bit phase index (top two bits select the quadrant)
//   sin_o       : signed sine, full scale +/-(2^(SIN_W-1)-1), one cycle after phase_idx_i
module mpx_sine_lut #(
  parameter int unsigned LUT_AW = 8,
  parameter int unsigned SIN_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [LUT_AW+1:0]        phase_idx_i,
  output logic signed [SIN_W-1:0]  sin_o
);

  localparam int unsigned N = 1 << LUT_AW;

  // Entry a holds round(FS * sin(pi/2 * a/N)); Taylor series keeps the table
  // a pure constant without relying on $sin support.
  function automatic logic [SIN_W-2:0] rom_val(input int unsigned a);
    real x;
    real term;
    real acc;
    real fs;
    x    = 1.5707963267948966 * real'(a) / real'(N);
    term = x;
    acc  = x;
    for (int i = 1; i <= 9; i++) begin
      term = -term * x * x / real'((2 * i) * (2 * i + 1));
      acc  = acc + term;
    end
    fs = real'((1 << (SIN_W - 1)) - 1);
    return (SIN_W-1)'($rtoi(acc * fs + 0.5));
  endfunction

  logic [SIN_W-2:0] rom [0:N];

  for (genvar g = 0; g <= N; g++) begin : g_rom
    assign rom[g] = rom_val(g);
  end

  logic [1:0]              quad;
  logic [LUT_AW:0]         a_ext;
  logic [LUT_AW:0]         addr;
  logic signed [SIN_W-1:0] mag;
  logic signed [SIN_W-1:0] sin_d;
  logic signed [SIN_W-1:0] sin_q;

  always_comb begin
    quad  = phase_idx_i[LUT_AW+1:LUT_AW];
    a_ext = {1'b0, phase_idx_i[LUT_AW-1:0]};
    // Odd quadrants run the table backwards; N-a reaches tab[N] for a=0.
    addr  = quad[0] ? ((LUT_AW+1)'(N) - a_ext) : a_ext;
    mag   = {1'b0, rom[addr]};
    sin_d = quad[1] ? -mag : mag;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sin_q <= '0;
    end else begin
      sin_q <= sin_d;
    end
  end

  assign sin_o = sin_q;

endmodule

// File: rtl/stereo_mpx_encoder.sv
// Stereo multiplex encoder: mono + DSB-SC (L-R) subcarrier + pilot from one phase
// accumulator, five-stage pipeline, saturating output with clip statistics.
//   clk, reset         : clock, synchronous active-high reset
//   in_l, in_r         : signed audio samples, qualified by in_valid
//   mode               : 00 stereo, 01 mono, 10 pilot-only, 11 mono
//   pilot_gain         : unsigned pilot amplitude in output LSBs
//   phase_step         : pilot phase increment per sample
//   phase_sync         : zero the phase accumulator
//   clr_stat           : clear sat_flag / sat_cnt
//   mpx_out, mpx_valid : composite sample and its strobe
//   sat_flag, sat_cnt  : sticky clip flag, saturating clip count
module stereo_mpx_encoder
  import stereo_mpx_pkg::*;
#(
  parameter int unsigned W       = 16,
  parameter int unsigned SIN_W   = 16,
  parameter int unsigned PHASE_W = 32,
  parameter int unsigned LUT_AW  = 8,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [W-1:0]       in_l,
  input  logic [W-1:0]       in_r,
  input  logic               in_valid,
  input  logic [1:0]         mode,
  input  logic [W-1:0]       pilot_gain,
  input  logic [PHASE_W-1:0] phase_step,
  input  logic               phase_sync,
  input  logic               clr_stat,
  output logic [W-1:0]       mpx_out,
  output logic               mpx_valid,
  output logic               sat_flag,
  output logic [CNT_W-1:0]   sat_cnt
);

  localparam int unsigned KW = LUT_AW + 2;
  localparam int unsigned PW = W + SIN_W + 1;

  // S0: captured inputs and phase
  logic [PHASE_W-1:0] acc_q, acc_d, p_d, p0_q;
  logic signed [W-1:0] l0_q, r0_q;
  logic [W-1:0]       gain0_q;
  mpx_mode_e          mode0_q;
  logic               v0_q;
  // S1: sum/diff and LUT indices
  logic signed [W:0]  l_ext, r_ext, sum_lr, dif_lr, m1_q, d1_q;
  logic [KW-1:0]      kp1_q, ks1_q;
  logic [W-1:0]       gain1_q;
  mpx_mode_e          mode1_q;
  logic               v1_q;
  // S2: LUT outputs (registered inside the LUTs)
  logic signed [SIN_W-1:0] s19, s38;
  logic signed [W:0]  m2_q, d2_q, gain_ext;
  logic [W-1:0]       gain2_q;
  mpx_mode_e          mode2_q;
  logic               v2_q;
  // S3: products
  logic signed [PW-1:0] prod_sub, prod_pil;
  logic signed [W:0]  m3_q, sub3_q, pil3_q;
  mpx_mode_e          mode3_q;
  logic               v3_q;
  // S4: sum, saturate, outputs
  logic signed [W+1:0] sum_d;
  logic signed [63:0]  sat_val;
  logic                clip_d;
  logic [W-1:0]        out_q;
  logic                valid_q, flag_q;
  logic [CNT_W-1:0]    cnt_q;

  always_comb begin
    acc_d = acc_q;
    p_d   = acc_q;
    if (phase_sync) begin
      p_d   = '0;
      acc_d = in_valid ? phase_step : '0;
    end else if (in_valid) begin
      acc_d = acc_q + phase_step;
    end
  end

  always_comb begin
    l_ext  = {l0_q[W-1], l0_q};
    r_ext  = {r0_q[W-1], r0_q};
    sum_lr = l_ext + r_ext;
    dif_lr = l_ext - r_ext;
  end

  always_comb begin
    gain_ext = {1'b0, gain2_q};
    prod_sub = PW'(d2_q) * PW'(s38);
    prod_pil = PW'(s19) * PW'(gain_ext);
  end

  always_comb begin
    case (mode3_q)
      MPX_STEREO: sum_d = (W+2)'(m3_q) + (W+2)'(sub3_q) + (W+2)'(pil3_q);
      MPX_PILOT:  sum_d = (W+2)'(pil3_q);
      default:    sum_d = (W+2)'(m3_q);
    endcase
    sat_val = mpx_saturate(64'(sum_d), W, clip_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;  p0_q <= '0;  l0_q <= '0;  r0_q <= '0;
      gain0_q <= '0;  mode0_q <= MPX_STEREO;  v0_q <= 1'b0;
      m1_q <= '0;  d1_q <= '0;  kp1_q <= '0;  ks1_q <= '0;
      gain1_q <= '0;  mode1_q <= MPX_STEREO;  v1_q <= 1'b0;
      m2_q <= '0;  d2_q <= '0;  gain2_q <= '0;  mode2_q <= MPX_STEREO;  v2_q <= 1'b0;
      m3_q <= '0;  sub3_q <= '0;  pil3_q <= '0;  mode3_q <= MPX_STEREO;  v3_q <= 1'b0;
      out_q <= '0;  valid_q <= 1'b0;  flag_q <= 1'b0;  cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      v0_q  <= in_valid;
      if (in_valid) begin
        p0_q    <= p_d;
        l0_q    <= in_l;
        r0_q    <= in_r;
        gain0_q <= pilot_gain;
        mode0_q <= mpx_mode_e'(mode);
      end
      m1_q    <= sum_lr >>> 1;
      d1_q    <= dif_lr >>> 1;
      kp1_q   <= KW'(p0_q >> (PHASE_W - KW));
      // Subcarrier index is the top of 2p; the dropped MSB is the mod-2^PHASE_W wrap.
      ks1_q   <= KW'(p0_q >> (PHASE_W - KW - 1));
      gain1_q <= gain0_q;
      mode1_q <= mode0_q;
      v1_q    <= v0_q;
      m2_q    <= m1_q;
      d2_q    <= d1_q;
      gain2_q <= gain1_q;
      mode2_q <= mode1_q;
      v2_q    <= v1_q;
      m3_q    <= m2_q;
      sub3_q  <= (W+1)'(prod_sub >>> (SIN_W - 1));
      pil3_q  <= (W+1)'(prod_pil >>> (SIN_W - 1));
      mode3_q <= mode2_q;
      v3_q    <= v2_q;
      valid_q <= v3_q;
      if (v3_q) begin
        out_q <= W'(sat_val);
      end
      if (clr_stat) begin
        flag_q <= 1'b0;
        cnt_q  <= '0;
      end else if (v3_q && clip_d) begin
        flag_q <= 1'b1;
        if (!(&cnt_q)) begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  mpx_sine_lut #(.LUT_AW(LUT_AW), .SIN_W(SIN_W)) u_lut_pilot (
    .clk         (clk),
    .reset       (reset),
    .phase_idx_i (kp1_q),
    .sin_o       (s19)
  );

  mpx_sine_lut #(.LUT_AW(LUT_AW), .SIN_W(SIN_W)) u_lut_sub (
    .clk         (clk),
    .reset       (reset),
    .phase_idx_i (ks1_q),
    .sin_o       (s38)
  );

  assign mpx_out   = out_q;
  assign mpx_valid = valid_q;
  assign sat_flag  = flag_q;
  assign sat_cnt   = cnt_q;

endmodule

// File: tb/tb_stereo_mpx_encoder.sv
// Directed, table-driven bench for stereo_mpx_encoder at default parameters.
module tb_stereo_mpx_encoder;
  import stereo_mpx_pkg::*;

  logic        clk = 1'b0;
  logic        reset, in_valid, phase_sync, clr_stat;
  logic [15:0] in_l, in_r, pilot_gain;
  logic [1:0]  mode;
  logic [31:0] phase_step;
  logic [15:0] mpx_out;
  logic        mpx_valid, sat_flag;
  logic [15:0] sat_cnt;

  stereo_mpx_encoder dut (
    .clk        (clk),
    .reset      (reset),
    .in_l       (in_l),
    .in_r       (in_r),
    .in_valid   (in_valid),
    .mode       (mode),
    .pilot_gain (pilot_gain),
    .phase_step (phase_step),
    .phase_sync (phase_sync),
    .clr_stat   (clr_stat),
    .mpx_out    (mpx_out),
    .mpx_valid  (mpx_valid),
    .sat_flag   (sat_flag),
    .sat_cnt    (sat_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic        sync;
    logic [1:0]  md;
    int          l;
    int          r;
    int          gain;
    logic [31:0] step;
    int          exp;
  } vec_t;

  localparam logic [31:0] S30 = 32'h4000_0000;
  localparam logic [31:0] S29 = 32'h2000_0000;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  logic rst_sampled = 1'b1;
  logic mon_en = 1'b0;
  int   last_out = 0;
  int   exp_q[$];
  int   iss_q[$];
  vec_t tbl[$];

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_sampled <= reset;
  end

  // Scoreboard: value, latency and hold between strobes.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rst_sampled) begin
        last_out = 0;
      end else if (mpx_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          int e;
          int is;
          e  = exp_q.pop_front();
          is = iss_q.pop_front();
          chk("mpx_out", int'($signed(mpx_out)), e);
          chk("latency", cyc - is, int'(MPX_LAT));
          last_out = e;
        end
      end else begin
        chk("hold", int'($signed(mpx_out)), last_out);
      end
    end
  end

  task automatic drive(input vec_t v);
    in_valid   = v.vld;
    phase_sync = v.sync;
    mode       = v.md;
    in_l       = 16'(v.l);
    in_r       = 16'(v.r);
    pilot_gain = 16'(v.gain);
    phase_step = v.step;
    if (v.vld) begin
      exp_q.push_back(v.exp);
      iss_q.push_back(cyc);
    end
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    phase_sync = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sat_period(input logic first_sync);
    drive('{1'b1, first_sync, 2'b00, 32767, 32767, 3000, S30, 32767});
    drive('{1'b1, 1'b0, 2'b00, 32767, 32767, 3000, S30, 32767});
    drive('{1'b1, 1'b0, 2'b00, 32767, 32767, 3000, S30, 32767});
    drive('{1'b1, 1'b0, 2'b00, 32767, 32767, 3000, S30, 29767});
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;  in_valid = 1'b0;  phase_sync = 1'b0;  clr_stat = 1'b0;
    in_l = '0;  in_r = '0;  pilot_gain = '0;  mode = 2'b00;  phase_step = S30;

    // Reset with in_valid toggling: nothing may leak out afterwards.
    for (int i = 0; i < 3; i++) begin
      in_valid = ~in_valid;
      in_l     = 16'($urandom);
      in_r     = 16'($urandom);
      @(posedge clk);
      #1;
    end
    chk("rst_mpx_out", int'(mpx_out), 0);
    chk("rst_mpx_valid", int'(mpx_valid), 0);
    chk("rst_sat_cnt", int'(sat_cnt), 0);
    chk("rst_sat_flag", int'(sat_flag), 0);
    reset    = 1'b0;
    in_valid = 1'b0;
    mon_en   = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end

    // Mono, back-to-back with a gap; mode 11 decodes as mono with floor shift.
    tbl.push_back('{1'b1, 1'b1, 2'b01, 1000, 1000, 5000, S30, 1000});
    tbl.push_back('{1'b1, 1'b0, 2'b01, 1000, 1000, 5000, S30, 1000});
    tbl.push_back('{1'b1, 1'b0, 2'b01, 1000, 1000, 5000, S30, 1000});
    tbl.push_back('{1'b0, 1'b0, 2'b01, 0, 0, 0, S30, 0});
    tbl.push_back('{1'b1, 1'b0, 2'b01, 1000, 1000, 5000, S30, 1000});
    tbl.push_back('{1'b1, 1'b0, 2'b11, 2000, -3001, 5000, S30, -501});
    // Subcarrier only.
    tbl.push_back('{1'b1, 1'b1, 2'b00, 8000, -8000, 0, S29, 0});
    tbl.push_back('{1'b1, 1'b0, 2'b00, 8000, -8000, 0, S29, 7999});
    tbl.push_back('{1'b1, 1'b0, 2'b00, 8000, -8000, 0, S29, 0});
    tbl.push_back('{1'b1, 1'b0, 2'b00, 8000, -8000, 0, S29, -8000});
    tbl.push_back('{1'b1, 1'b0, 2'b00, 8000, -8000, 0, S29, 0});
    tbl.push_back('{1'b1, 1'b0, 2'b00, 8000, -8000, 0, S29, 7999});
    // Pilot only; audio must be ignored. Mid-stream sync with and without in_valid.
    tbl.push_back('{1'b1, 1'b1, 2'b10, 5000, -7000, 2000, S30, 0});
    tbl.push_back('{1'b1, 1'b0, 2'b10, 5000, -7000, 2000, S30, 1999});
    tbl.push_back('{1'b1, 1'b0, 2'b10, 5000, -7000, 2000, S30, 0});
    tbl.push_back('{1'b1, 1'b0, 2'b10, 5000, -7000, 2000, S30, -2000});
    tbl.push_back('{1'b1, 1'b0, 2'b10, 5000, -7000, 2000, S30, 0});
    tbl.push_back('{1'b1, 1'b0, 2'b10, 5000, -7000, 2000, S30, 1999});
    tbl.push_back('{1'b1, 1'b1, 2'b10, 5000, -7000, 2000, S30, 0});
    tbl.push_back('{1'b1, 1'b0, 2'b10, 5000, -7000, 2000, S30, 1999});
    tbl.push_back('{1'b0, 1'b1, 2'b10, 0, 0, 2000, S30, 0});
    tbl.push_back('{1'b1, 1'b0, 2'b10, 5000, -7000, 2000, S30, 0});
    tbl.push_back('{1'b1, 1'b0, 2'b10, 5000, -7000, 2000, S30, 1999});
    // Full stereo: m=2000, d=1000; pilot hits the 45-degree entry (23170).
    tbl.push_back('{1'b1, 1'b1, 2'b00, 3000, 1000, 2000, S29, 2000});
    tbl.push_back('{1'b1, 1'b0, 2'b00, 3000, 1000, 2000, S29, 4413});
    tbl.push_back('{1'b1, 1'b0, 2'b00, 3000, 1000, 2000, S29, 3999});
    tbl.push_back('{1'b1, 1'b0, 2'b00, 3000, 1000, 2000, S29, 2414});
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
    end
    drain();
    chk("no_clip_flag", int'(sat_flag), 0);
    chk("no_clip_cnt", int'(sat_cnt), 0);

    // Saturation: one clip per four-sample period.
    sat_period(1'b1);
    drain();
    chk("sat_flag_p1", int'(sat_flag), 1);
    chk("sat_cnt_p1", int'(sat_cnt), 1);
    sat_period(1'b0);
    drain();
    chk("sat_cnt_p2", int'(sat_cnt), 2);

    // clr_stat takes effect on the next edge.
    clr_stat = 1'b1;
    chk("clr_before_edge", int'(sat_cnt), 2);
    @(posedge clk);
    #1;
    clr_stat = 1'b0;
    chk("clr_flag", int'(sat_flag), 0);
    chk("clr_cnt", int'(sat_cnt), 0);

    // clr_stat on the very edge the clipped sample lands: clear wins.
    for (int c = 0; c < 8; c++) begin
      clr_stat = (c == 5);
      if (c == 0)      drive('{1'b1, 1'b1, 2'b00, 32767, 32767, 3000, S30, 32767});
      else if (c == 1) drive('{1'b1, 1'b0, 2'b00, 32767, 32767, 3000, S30, 32767});
      else if (c == 2) drive('{1'b1, 1'b0, 2'b00, 32767, 32767, 3000, S30, 32767});
      else if (c == 3) drive('{1'b1, 1'b0, 2'b00, 32767, 32767, 3000, S30, 29767});
      else             drive('{1'b0, 1'b0, 2'b00, 0, 0, 3000, S30, 0});
    end
    clr_stat = 1'b0;
    drain();
    chk("clr_vs_clip_flag", int'(sat_flag), 0);
    chk("clr_vs_clip_cnt", int'(sat_cnt), 0);

    // Reset two cycles after an in_valid: the sample must vanish.
    in_valid = 1'b1;  mode = 2'b01;  in_l = 16'd1234;  in_r = 16'd1234;  phase_step = S29;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
    end
    chk("mid_rst_valid", int'(mpx_valid), 0);
    chk("mid_rst_out", int'(mpx_out), 0);
    // Accumulator restarts at zero without a phase_sync.
    drive('{1'b1, 1'b0, 2'b10, 0, 0, 2000, S30, 0});
    drive('{1'b1, 1'b0, 2'b10, 0, 0, 2000, S30, 1999});
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
